mc_main_ctrl: RTL and testbench

- Multi-cycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction through fetch, decode, execute, memory and writeback states, with a request/acknowledge memory handshake and a wait-state timeout.
- Drives the shared datapath (PC, IR, ALU, register file, unified memory port) cycle by cycle.
- Output aluop uses the same codes the existing aludec consumes.

---
 rtl/mc_main_ctrl_pkg.sv | 76 +++++++
 rtl/mc_main_ctrl_op_class.sv | 45 ++++
 rtl/mc_main_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_main_ctrl_pkg.sv
// mc_main_ctrl_pkg: opcodes, aludec codes, state and mux encodings
// shared by the multi-cycle main controller and its op classifier.
package mc_main_ctrl_pkg;

  localparam logic [5:0] op_rtype  = 6'b000000;
  localparam logic [5:0] op_regimm = 6'b000001;
  localparam logic [5:0] op_j      = 6'b000010;
  localparam logic [5:0] op_jal    = 6'b000011;
  localparam logic [5:0] op_beq    = 6'b000100;
  localparam logic [5:0] op_bne    = 6'b000101;
  localparam logic [5:0] op_blez   = 6'b000110;
  localparam logic [5:0] op_bgtz   = 6'b000111;
  localparam logic [5:0] op_addi   = 6'b001000;
  localparam logic [5:0] op_addiu  = 6'b001001;
  localparam logic [5:0] op_slti   = 6'b001010;
  localparam logic [5:0] op_sltiu  = 6'b001011;
  localparam logic [5:0] op_andi   = 6'b001100;
  localparam logic [5:0] op_ori    = 6'b001101;
  localparam logic [5:0] op_xori   = 6'b001110;
  localparam logic [5:0] op_lui    = 6'b001111;
  localparam logic [5:0] op_lb     = 6'b100000;
  localparam logic [5:0] op_lh     = 6'b100001;
  localparam logic [5:0] op_lw     = 6'b100011;
  localparam logic [5:0] op_lbu    = 6'b100100;
  localparam logic [5:0] op_lhu    = 6'b100101;
  localparam logic [5:0] op_sb     = 6'b101000;
  localparam logic [5:0] op_sh     = 6'b101001;
  localparam logic [5:0] op_sw     = 6'b101011;

  localparam logic [3:0] aluop_add   = 4'd0;
  localparam logic [3:0] aluop_sub   = 4'd1;
  localparam logic [3:0] aluop_rtype = 4'd2;
  localparam logic [3:0] aluop_and   = 4'd3;
  localparam logic [3:0] aluop_or    = 4'd4;
  localparam logic [3:0] aluop_xor   = 4'd5;
  localparam logic [3:0] aluop_slt   = 4'd6;
  localparam logic [3:0] aluop_sltu  = 4'd7;
  localparam logic [3:0] aluop_lui   = 4'd8;

  localparam logic [1:0] pcsrc_alu    = 2'b00;
  localparam logic [1:0] pcsrc_aluout = 2'b01;
  localparam logic [1:0] pcsrc_jump   = 2'b10;
  localparam logic [1:0] pcsrc_exc    = 2'b11;

  localparam logic [1:0] srcb_rt    = 2'b00;
  localparam logic [1:0] srcb_four  = 2'b01;
  localparam logic [1:0] srcb_imm   = 2'b10;
  localparam logic [1:0] srcb_immsh = 2'b11;

  typedef enum logic [3:0] {
    s_idle   = 4'd0,
    s_fetch  = 4'd1,
    s_decode = 4'd2,
    s_memadr = 4'd3,
    s_memrd  = 4'd4,
    s_memwr  = 4'd5,
    s_memwb  = 4'd6,
    s_exec_r = 4'd7,
    s_exec_i = 4'd8,
    s_aluwb  = 4'd9,
    s_branch = 4'd10,
    s_jump   = 4'd11,
    s_exc    = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    cl_load   = 3'd0,
    cl_store  = 3'd1,
    cl_rtype  = 3'd2,
    cl_imm    = 3'd3,
    cl_branch = 3'd4,
    cl_jump   = 3'd5,
    cl_undef  = 3'd6
  } op_class_t;

endpackage

// File: rtl/mc_main_ctrl_op_class.sv
// mc_op_class: combinational opcode classifier giving the instruction
// class for DECODE and the immediate-form aludec code for EXEC_I.
module mc_op_class
  import mc_main_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  cls,
  output logic [3:0] aluop
);

  always_comb begin
    cls = cl_undef;
    unique case (1'b1)
      (op inside {op_lb, op_lbu, op_lh, op_lhu, op_lw}):
        cls = cl_load;
      (op inside {op_sb, op_sh, op_sw}):
        cls = cl_store;
      (op == op_rtype):
        cls = cl_rtype;
      (op inside {op_addi, op_addiu, op_slti, op_sltiu,
                  op_andi, op_ori, op_xori, op_lui}):
        cls = cl_imm;
      (op inside {op_beq, op_bne, op_blez, op_bgtz, op_regimm}):
        cls = cl_branch;
      (op inside {op_j, op_jal}):
        cls = cl_jump;
      default:
        cls = cl_undef;
    endcase
  end

  always_comb begin
    aluop = aluop_add;
    unique case (op)
      op_slti:  aluop = aluop_slt;
      op_sltiu: aluop = aluop_sltu;
      op_andi:  aluop = aluop_and;
      op_ori:   aluop = aluop_or;
      op_xori:  aluop = aluop_xor;
      op_lui:   aluop = aluop_lui;
      default:  aluop = aluop_add;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multi-cycle MIPS main controller with memory handshake
// and wait-state timeout. MC_MAIN_CTRL_RI_EXC_EN adds the RI exception.
module mc_main_ctrl
  import mc_main_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               hold,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic [ALUOP_W-1:0] aluop,
  output logic               bus_err
`ifdef MC_MAIN_CTRL_RI_EXC_EN
  ,
  output logic               ri_exc
`endif
);

  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam int TL = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [CW-1:0] to_last = CW'(TL);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rd_flag;
  logic            err_q;
  op_class_t       cls;
  logic [3:0]      imm_alu;
  logic [3:0]      alu_code;
  logic            memst;
  logic            tmo;

  mc_op_class u_class (
    .op    (op),
    .cls   (cls),
    .aluop (imm_alu)
  );

  assign memst = (state == s_fetch) ||
                 (state == s_memrd) ||
                 (state == s_memwr);
  assign tmo   = (MEM_TIMEOUT != 0) && (cnt == to_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= s_idle;
      cnt     <= '0;
      rd_flag <= 1'b0;
      err_q   <= 1'b0;
    end else if (!hold) begin
      err_q <= 1'b0;
      if (memst) begin
        // ack beats a timeout landing in the same cycle
        if (mem_ack) begin
          cnt <= '0;
          unique case (state)
            s_fetch: state <= s_decode;
            s_memrd: state <= s_memwb;
            default: state <= s_fetch;
          endcase
        end else if (tmo) begin
          cnt   <= '0;
          err_q <= 1'b1;
          state <= s_fetch;
        end else if (cnt != '1) begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
        unique case (state)
          s_idle:   state <= s_fetch;
          s_decode: begin
            unique case (cls)
              cl_load,
              cl_store:  state <= s_memadr;
              cl_rtype:  state <= s_exec_r;
              cl_imm:    state <= s_exec_i;
              cl_branch: state <= s_branch;
              cl_jump:   state <= s_jump;
`ifdef MC_MAIN_CTRL_RI_EXC_EN
              default:   state <= s_exc;
`else
              default:   state <= s_fetch;
`endif
            endcase
          end
          s_memadr: begin
            if (cls == cl_load) state <= s_memrd;
            else                state <= s_memwr;
          end
          s_exec_r: begin
            rd_flag <= 1'b1;
            state   <= s_aluwb;
          end
          s_exec_i: begin
            rd_flag <= 1'b0;
            state   <= s_aluwb;
          end
          s_memwb,
          s_aluwb,
          s_branch,
          s_jump,
          s_exc:    state <= s_fetch;
          default:  state <= s_idle;
        endcase
      end
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    branch   = 1'b0;
    pcsrc    = pcsrc_alu;
    alusrca  = 1'b0;
    alusrcb  = srcb_rt;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alu_code = aluop_add;
`ifdef MC_MAIN_CTRL_RI_EXC_EN
    ri_exc   = 1'b0;
`endif
    unique case (state)
      s_fetch: begin
        mem_req  = 1'b1;
        alusrcb  = srcb_four;
        ir_write = mem_ack & ~hold;
        pc_write = mem_ack & ~hold;
      end
      s_decode: alusrcb = srcb_immsh;
      s_memadr: begin
        alusrca = 1'b1;
        alusrcb = srcb_imm;
      end
      s_memrd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      s_memwr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      s_memwb: begin
        memtoreg = 1'b1;
        regwrite = ~hold;
      end
      s_exec_r: begin
        alusrca  = 1'b1;
        alu_code = aluop_rtype;
      end
      s_exec_i: begin
        alusrca  = 1'b1;
        alusrcb  = srcb_imm;
        alu_code = imm_alu;
      end
      s_aluwb: begin
        regdst   = rd_flag;
        regwrite = ~hold;
      end
      s_branch: begin
        alusrca  = 1'b1;
        alu_code = aluop_sub;
        branch   = 1'b1;
        pcsrc    = pcsrc_aluout;
      end
      s_jump: begin
        pc_write = ~hold;
        pcsrc    = pcsrc_jump;
      end
`ifdef MC_MAIN_CTRL_RI_EXC_EN
      s_exc: begin
        ri_exc   = 1'b1;
        pc_write = ~hold;
        pcsrc    = pcsrc_exc;
      end
`endif
      default: ;
    endcase
  end

  assign aluop   = ALUOP_W'(alu_code);
  assign bus_err = err_q & ~hold;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: directed plus randomized bench for mc_main_ctrl;
// expected outputs come from a per-instruction cycle model.
module tb_mc_main_ctrl;

  localparam int TMO = 16;

  typedef struct packed {
    logic       ri_exc;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [3:0] aluop;
    logic       bus_err;
  } outs_t;

  logic       clk;
  logic       rst;
  logic       hold;
  logic       mem_ack;
  logic [5:0] op;
  logic       mem_req, mem_we, iord, ir_write, pc_write, branch;
  logic [1:0] pcsrc, alusrcb;
  logic       alusrca, regdst, memtoreg, regwrite, bus_err;
  logic [3:0] aluop;
  logic       ri_exc_w;

  int checks;
  int failures;
  int force_hold;
  int hold_rate;
  bit err_next;
  int wr_seen;
  int err_seen;

  logic [5:0] ops [28] = '{
    6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
    6'b000101, 6'b000110, 6'b000111, 6'b001000, 6'b001001,
    6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110,
    6'b001111, 6'b100000, 6'b100001, 6'b100011, 6'b100100,
    6'b100101, 6'b101000, 6'b101001, 6'b101011,
    6'b111111, 6'b010000, 6'b011100, 6'b110000
  };

  mc_main_ctrl #(.ALUOP_W(4), .MEM_TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .hold     (hold),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .iord     (iord),
    .ir_write (ir_write),
    .pc_write (pc_write),
    .branch   (branch),
    .pcsrc    (pcsrc),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .aluop    (aluop),
    .bus_err  (bus_err)
`ifdef MC_MAIN_CTRL_RI_EXC_EN
    ,
    .ri_exc   (ri_exc_w)
`endif
  );

`ifndef MC_MAIN_CTRL_RI_EXC_EN
  assign ri_exc_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic outs_t obs();
    outs_t o;
    o.ri_exc   = ri_exc_w;
    o.mem_req  = mem_req;
    o.mem_we   = mem_we;
    o.iord     = iord;
    o.ir_write = ir_write;
    o.pc_write = pc_write;
    o.branch   = branch;
    o.pcsrc    = pcsrc;
    o.alusrca  = alusrca;
    o.alusrcb  = alusrcb;
    o.regdst   = regdst;
    o.memtoreg = memtoreg;
    o.regwrite = regwrite;
    o.aluop    = aluop;
    o.bus_err  = bus_err;
    return o;
  endfunction

  // 0 load, 1 store, 2 rtype, 3 imm alu, 4 branch, 5 jump, 6 undefined
  function automatic int cls_of(input logic [5:0] o);
    if (o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return 0;
    if (o inside {6'h28, 6'h29, 6'h2B}) return 1;
    if (o == 6'h00) return 2;
    if (o inside {[6'h08:6'h0F]}) return 3;
    if (o inside {[6'h04:6'h07], 6'h01}) return 4;
    if (o inside {6'h02, 6'h03}) return 5;
    return 6;
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] o);
    case (o)
      6'h0A:   return 4'd6;
      6'h0B:   return 4'd7;
      6'h0C:   return 4'd3;
      6'h0D:   return 4'd4;
      6'h0E:   return 4'd5;
      6'h0F:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic int rnd_lat();
    int x;
    x = int'($urandom_range(31));
    if (x == 0) return 99;
    if (x == 1) return TMO - 1;
    return x % 4;
  endfunction

  task automatic chk(input string tag, input outs_t o, input outs_t e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One model cycle, optionally preceded by hold cycles that freeze it.
  task automatic step(input logic ack, input outs_t e, input string tag);
    int    nh;
    outs_t ee;
    outs_t eh;
    ee = e;
    if (err_next) begin
      ee.bus_err = 1'b1;
      err_next   = 1'b0;
    end
    nh = force_hold;
    force_hold = 0;
    if (nh == 0 && hold_rate != 0 &&
        $urandom_range(hold_rate - 1) == 0)
      nh = int'($urandom_range(3, 1));
    eh = ee;
    eh.ir_write = 1'b0;
    eh.pc_write = 1'b0;
    eh.regwrite = 1'b0;
    eh.bus_err  = 1'b0;
    for (int k = 0; k < nh; k++) begin
      hold    = 1'b1;
      mem_ack = 1'($urandom_range(1));
      #1;
      chk({tag, "_hold"}, obs(), eh);
      @(negedge clk);
    end
    hold    = 1'b0;
    mem_ack = ack;
    #1;
    chk(tag, obs(), ee);
    if (regwrite === 1'b1) wr_seen++;
    if (bus_err === 1'b1) err_seen++;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic mem_phase(input outs_t base, input int lat,
                           input bit is_fetch, input string tag,
                           output bit ok);
    outs_t a;
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (i == lat) begin
        a = base;
        if (is_fetch) begin
          a.ir_write = 1'b1;
          a.pc_write = 1'b1;
        end
        step(1'b1, a, tag);
        ok = 1'b1;
        return;
      end
      step(1'b0, base, tag);
    end
    err_next = 1'b1;
  endtask

  task automatic do_instr(input logic [5:0] o, input int lf,
                          input int lm, input int hd);
    outs_t r;
    bit    ok;
    int    c;
    op = o;
    r = '0;
    r.mem_req = 1'b1;
    r.alusrcb = 2'b01;
    mem_phase(r, lf, 1'b1, "fetch", ok);
    if (!ok) return;
    c = cls_of(o);
    r = '0;
    r.alusrcb = 2'b11;
    force_hold = hd;
    step(1'b0, r, "decode");
    case (c)
      0, 1: begin
        r = '0;
        r.alusrca = 1'b1;
        r.alusrcb = 2'b10;
        step(1'b0, r, "memadr");
        r = '0;
        r.mem_req = 1'b1;
        r.iord    = 1'b1;
        if (c == 0) begin
          mem_phase(r, lm, 1'b0, "memrd", ok);
          if (!ok) return;
          r = '0;
          r.memtoreg = 1'b1;
          r.regwrite = 1'b1;
          step(1'b0, r, "memwb");
        end else begin
          r.mem_we = 1'b1;
          mem_phase(r, lm, 1'b0, "memwr", ok);
        end
      end
      2, 3: begin
        r = '0;
        r.alusrca = 1'b1;
        r.alusrcb = (c == 2) ? 2'b00 : 2'b10;
        r.aluop   = (c == 2) ? 4'd2 : imm_alu(o);
        step(1'b0, r, (c == 2) ? "exec_r" : "exec_i");
        r = '0;
        r.regwrite = 1'b1;
        r.regdst   = (c == 2);
        step(1'b0, r, "aluwb");
      end
      4: begin
        r = '0;
        r.alusrca = 1'b1;
        r.aluop   = 4'd1;
        r.branch  = 1'b1;
        r.pcsrc   = 2'b01;
        step(1'b0, r, "branch");
      end
      5: begin
        r = '0;
        r.pc_write = 1'b1;
        r.pcsrc    = 2'b10;
        step(1'b0, r, "jump");
      end
      default: begin
`ifdef MC_MAIN_CTRL_RI_EXC_EN
        r = '0;
        r.ri_exc   = 1'b1;
        r.pc_write = 1'b1;
        r.pcsrc    = 2'b11;
        step(1'b0, r, "exc");
`endif
      end
    endcase
  endtask

  task automatic mid_reset();
    outs_t r;
    outs_t z;
    z = '0;
    r = '0;
    r.mem_req = 1'b1;
    r.alusrcb = 2'b01;
    step(1'b0, r, "pre_rst");
    step(1'b0, r, "pre_rst");
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst", obs(), z);
    rst = 1'b0;
    err_next = 1'b0;
    step(1'b0, z, "mid_rst_idle");
  endtask

  initial begin
    outs_t z;
    z = '0;
    checks = 0;
    failures = 0;
    force_hold = 0;
    hold_rate = 0;
    err_next = 1'b0;
    wr_seen = 0;
    err_seen = 0;
    rst = 1'b1;
    hold = 1'b0;
    mem_ack = 1'b0;
    op = '0;
    @(negedge clk);
    step(1'b0, z, "rst0");
    step(1'b0, z, "rst1");
    rst = 1'b0;
    step(1'b0, z, "idle");

    wr_seen = 0;
    do_instr(6'b100011, 2, 2, 0);
    chk_int("lw_regwrite_once", wr_seen, 1);

    wr_seen = 0;
    do_instr(6'b000000, 0, 0, 0);
    do_instr(6'b001101, 0, 0, 0);
    chk_int("r_ori_writes", wr_seen, 2);

    wr_seen = 0;
    err_seen = 0;
    do_instr(6'b101011, 0, 99, 0);
    chk_int("sw_tmo_nowrite", wr_seen, 0);
    do_instr(6'b000100, 0, 0, 5);
    chk_int("sw_tmo_buserr", err_seen, 1);

    wr_seen = 0;
    do_instr(6'b111111, 0, 0, 0);
    chk_int("undef_nowrite", wr_seen, 0);

    err_seen = 0;
    do_instr(6'b100011, TMO - 1, TMO - 1, 0);
    chk_int("ack_wins", err_seen, 0);

    err_seen = 0;
    do_instr(6'b100011, 99, 0, 0);
    do_instr(6'b000010, 0, 0, 0);
    chk_int("fetch_tmo_buserr", err_seen, 1);

    mid_reset();
    do_instr(6'b001111, 1, 0, 0);

    hold_rate = 8;
    for (int n = 0; n < 300; n++) begin
      do_instr(ops[$urandom_range(27)], rnd_lat(), rnd_lat(), 0);
    end
    hold_rate = 0;
    do_instr(6'b000011, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
